// File: rtl/stim_gen_pkg.sv
// Shared definitions for the stimulus generator: FSM encodings, LFSR constants and the
// directed corner-vector table.
package stim_gen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CORNER = 2'd1;
  localparam logic [1:0] ST_RANDOM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;
  localparam int          NUM_CORNER        = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } operand_pair_t;

  function automatic operand_pair_t corner_vec(input logic [2:0] idx);
    operand_pair_t p;
    case (idx)
      3'd0:    p = '{a: 32'h0000_0000, b: 32'h0000_0000};
      3'd1:    p = '{a: 32'h0000_0000, b: 32'hFFFF_FFFF};
      3'd2:    p = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001};
      3'd3:    p = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001};
      3'd4:    p = '{a: 32'h8000_0000, b: 32'h8000_0000};
      3'd5:    p = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
      3'd6:    p = '{a: 32'hAAAA_AAAA, b: 32'h5555_5555};
      default: p = '{a: 32'h0000_0001, b: 32'h0000_0001};
    endcase
    return p;
  endfunction

  // Galois right-shift step; the tap mask is applied when the bit shifted out is set.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/stim_gen_lfsr32.sv
// 32-bit Galois LFSR with seed load; an all-zero seed is replaced so the register never locks up.
module lfsr32
  import stim_gen_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state,
  output logic [31:0] next
);

  assign next = lfsr_next(state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 32'h0) ? DEFAULT_SEED : seed;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/stim_gen.sv
// Operand stimulus source: 8 directed corner vectors followed by LFSR-random vectors for a
// run of N tests, with a level start / sticky done handshake to the host.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] DEFAULT_SEED = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [31:0]      i_num_tests,
  input  logic [31:0]      i_seed,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_count
);

  logic [1:0]    state;
  logic [31:0]   num;
  logic [2:0]    idx;
  logic          accept;
  logic          step;
  logic [31:0]   count_inc;
  logic          last;
  operand_pair_t corner;
  logic [31:0]   lfsr_a_nxt;
  logic [31:0]   lfsr_b_nxt;
  logic [31:0]   unused_lfsr_a_state;
  logic [31:0]   unused_lfsr_b_state;

  assign accept    = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign step      = (state == ST_RANDOM);
  assign count_inc = o_count + 32'd1;
  assign last      = (count_inc == num);
  assign corner    = corner_vec(idx);

  // B is seeded with the complement so the two operand streams differ for any seed.
  lfsr32 #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr_a (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .seed  (i_seed),
    .step  (step),
    .state (unused_lfsr_a_state),
    .next  (lfsr_a_nxt)
  );

  lfsr32 #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr_b (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .seed  (~i_seed),
    .step  (step),
    .state (unused_lfsr_b_state),
    .next  (lfsr_b_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      num      <= 32'h0;
      idx      <= 3'd0;
      o_dut_ia <= '0;
      o_dut_ib <= '0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_count  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          o_dut_ia <= '0;
          o_dut_ib <= '0;
          o_valid  <= 1'b0;
          if (i_start) begin
            num     <= i_num_tests;
            idx     <= 3'd0;
            o_count <= 32'h0;
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
            state   <= (i_num_tests == 32'h0) ? ST_DONE : ST_CORNER;
          end else begin
            o_busy <= 1'b0;
            o_done <= (state == ST_DONE);
          end
        end
        ST_CORNER: begin
          o_dut_ia <= corner.a;
          o_dut_ib <= corner.b;
          o_valid  <= 1'b1;
          o_count  <= count_inc;
          idx      <= idx + 3'd1;
          // A short run may finish before the corner table is exhausted.
          if (last) begin
            state <= ST_DONE;
          end else if (idx == 3'(NUM_CORNER - 1)) begin
            state <= ST_RANDOM;
          end
        end
        ST_RANDOM: begin
          o_dut_ia <= lfsr_a_nxt;
          o_dut_ib <= lfsr_b_nxt;
          o_valid  <= 1'b1;
          o_count  <= count_inc;
          if (last) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: a per-cycle vector table plus hand-written multi-cycle runs.
module tb_stim_gen;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [31:0] i_num_tests;
  logic [31:0] i_seed;
  logic [31:0] o_dut_ia;
  logic [31:0] o_dut_ib;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_count;

  int vectors;
  int miscompares;

  stim_gen dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_num_tests (i_num_tests),
    .i_seed      (i_seed),
    .o_dut_ia    (o_dut_ia),
    .o_dut_ib    (o_dut_ib),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] num;
    logic [31:0] seed;
    logic        valid;
    logic [31:0] ia;
    logic [31:0] ib;
    logic        busy;
    logic        done;
    logic [31:0] count;
  } vec_t;

  vec_t vecs [15];

  // Expected run vectors for seed=1: corner table, then the first three LFSR pairs.
  logic [31:0] exp_a [11];
  logic [31:0] exp_b [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic valid, input logic [31:0] ia,
                       input logic [31:0] ib, input logic busy, input logic done,
                       input logic [31:0] count);
    vectors++;
    if (o_valid !== valid || o_dut_ia !== ia || o_dut_ib !== ib ||
        o_busy !== busy || o_done !== done || o_count !== count) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b ia=%h ib=%h busy=%0b done=%0b count=%0d, want valid=%0b ia=%h ib=%h busy=%0b done=%0b count=%0d",
               name, o_valid, o_dut_ia, o_dut_ib, o_busy, o_done, o_count,
               valid, ia, ib, busy, done, count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    i_start     = 1'b0;
    i_num_tests = 32'd0;
    i_seed      = 32'd0;

    //            rst   start num    seed  | valid ia            ib            busy  done  count
    vecs[0]  = '{1'b1, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'd3, 32'd5, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 32'd1};
    vecs[7]  = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b1, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 32'd2};
    vecs[8]  = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFF, 32'h1,        1'b1, 1'b0, 32'd3};
    vecs[9]  = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'd3};
    vecs[10] = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'd3};
    vecs[11] = '{1'b0, 1'b1, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'd0};
    vecs[12] = '{1'b0, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'd0};
    vecs[13] = '{1'b0, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'd0};
    vecs[14] = '{1'b0, 1'b0, 32'd0, 32'd5, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'd0};

    exp_a[0] = 32'h00000000; exp_b[0] = 32'h00000000;
    exp_a[1] = 32'h00000000; exp_b[1] = 32'hFFFFFFFF;
    exp_a[2] = 32'hFFFFFFFF; exp_b[2] = 32'h00000001;
    exp_a[3] = 32'h7FFFFFFF; exp_b[3] = 32'h00000001;
    exp_a[4] = 32'h80000000; exp_b[4] = 32'h80000000;
    exp_a[5] = 32'hFFFFFFFF; exp_b[5] = 32'hFFFFFFFF;
    exp_a[6] = 32'hAAAAAAAA; exp_b[6] = 32'h55555555;
    exp_a[7] = 32'h00000001; exp_b[7] = 32'h00000001;
    exp_a[8] = 32'h80200003; exp_b[8] = 32'h7FFFFFFF;
    exp_a[9] = 32'hC0300002; exp_b[9] = 32'hBFDFFFFC;
    exp_a[10] = 32'h60180001; exp_b[10] = 32'h5FEFFFFE;

    // Reset, idle, N=3 run, then N=0 run started straight from DONE.
    for (int i = 0; i < 15; i++) begin
      reset       = vecs[i].rst;
      i_start     = vecs[i].start;
      i_num_tests = vecs[i].num;
      i_seed      = vecs[i].seed;
      tick();
      check($sformatf("table[%0d]", i), vecs[i].valid, vecs[i].ia, vecs[i].ib,
            vecs[i].busy, vecs[i].done, vecs[i].count);
    end

    // N=10, seed=1: eight corners then two LFSR pairs.
    i_start = 1'b1; i_num_tests = 32'd10; i_seed = 32'd1;
    tick();
    check("n10_accept", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("n10_vec%0d", i), 1'b1, exp_a[i], exp_b[i], 1'b1, 1'b0, 32'(i + 1));
    end
    tick();
    check("n10_done", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd10);
    tick();
    check("n10_done_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd10);

    // seed=0: A falls back to the default seed, B loads ~0.
    i_start = 1'b1; i_num_tests = 32'd9; i_seed = 32'd0;
    tick();
    check("seed0_accept", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("seed0_corner%0d", i), 1'b1, exp_a[i], exp_b[i], 1'b1, 1'b0, 32'(i + 1));
    end
    tick();
    check("seed0_random", 1'b1, 32'h56709234, 32'hFFDFFFFC, 1'b1, 1'b0, 32'd9);
    tick();
    check("seed0_done", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd9);

    // Start pulse during RANDOM is ignored; reset mid-run aborts.
    i_start = 1'b1; i_num_tests = 32'd20; i_seed = 32'd1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_vec10", 1'b1, exp_a[9], exp_b[9], 1'b1, 1'b0, 32'd10);
    i_start = 1'b1; i_num_tests = 32'd2; i_seed = 32'h1234;
    tick();
    check("start_ignored", 1'b1, exp_a[10], exp_b[10], 1'b1, 1'b0, 32'd11);
    i_start = 1'b0;
    tick();
    check("random_continues", 1'b1, 32'hB02C0003, 32'h2FF7FFFF, 1'b1, 1'b0, 32'd12);
    reset = 1'b1;
    tick();
    check("reset_abort", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    tick();
    check("post_reset_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    i_start = 1'b1; i_num_tests = 32'd1; i_seed = 32'd1;
    tick();
    check("n1_accept", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
    i_start = 1'b0;
    tick();
    check("n1_replay_corner0", 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'd1);
    tick();
    check("n1_done", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
